// File: rtl/plb_wr_arbiter_if.sv
// rtl/plb_wr_arbiter_if.sv - requester and PLB master signal bundle for the write arbiter
interface plb_wr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_wr_req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_cmdack;
    logic [NUM_REQ-1:0]        req_cmplt;
    logic [NUM_REQ-1:0]        req_error;
    logic [NUM_REQ-1:0]        grant;
    logic                      IP2Bus_MstWr_Req;
    logic [ADDR_W-1:0]         IP2Bus_Mst_Addr;
    logic [DATA_W-1:0]         IP2Bus_MstWr_d;
    logic                      Bus2IP_Mst_CmdAck;
    logic                      Bus2IP_Mst_Cmplt;
    logic                      Bus2IP_Mst_Error;
    logic                      timeout_flag;

    modport master (
        input  req_wr_req, req_addr, req_data,
        input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
        output req_cmdack, req_cmplt, req_error, grant,
        output IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d, timeout_flag
    );

    modport slave (
        output req_wr_req, req_addr, req_data,
        output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
        input  req_cmdack, req_cmplt, req_error, grant,
        input  IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d, timeout_flag
    );
endinterface

// File: rtl/plb_wr_arbiter.sv
// rtl/plb_wr_arbiter.sv - round-robin arbiter sharing one PLB single-beat write master port
module plb_wr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    plb_wr_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_CMPLT, RELEASE} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] grant_r;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic [CNT_W-1:0]   cnt;
    logic               mst_req;
    logic               to_pulse;
    logic               to_flag;
    logic [ADDR_W-1:0]  addr_r;
    logic               active;
    logic               cmplt_fwd;
    logic               tmo_hit;

    // Search starts one past the last granted requester so every requester gets a turn.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && bus.req_wr_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign active    = (state == REQ) || (state == WAIT_CMPLT);
    assign cmplt_fwd = active && bus.Bus2IP_Mst_Cmplt;
    assign tmo_hit   = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    assign bus.grant            = grant_r;
    assign bus.req_cmdack       = ((state == REQ) && bus.Bus2IP_Mst_CmdAck) ? grant_r : '0;
    assign bus.req_cmplt        = (cmplt_fwd || to_pulse) ? grant_r : '0;
    assign bus.req_error        = ((cmplt_fwd && bus.Bus2IP_Mst_Error) || to_pulse) ? grant_r : '0;
    assign bus.IP2Bus_MstWr_Req = mst_req;
    assign bus.IP2Bus_Mst_Addr  = addr_r;
    assign bus.timeout_flag     = to_flag;

    always_comb begin
        bus.IP2Bus_MstWr_d = '0;
        if (|grant_r)
            bus.IP2Bus_MstWr_d = bus.req_data[gidx*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant_r  <= '0;
            gidx     <= '0;
            ptr      <= IDX_W'(NUM_REQ - 1);
            cnt      <= '0;
            mst_req  <= 1'b0;
            to_pulse <= 1'b0;
            to_flag  <= 1'b0;
            addr_r   <= '0;
        end else begin
            to_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_r <= NUM_REQ'(1) << pick;
                        gidx    <= pick;
                        addr_r  <= bus.req_addr[pick*ADDR_W +: ADDR_W];
                        cnt     <= '0;
                        mst_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ, WAIT_CMPLT: begin
                    cnt <= cnt + 1'b1;
                    // A completion on the timeout cycle is treated as a normal finish.
                    if (bus.Bus2IP_Mst_Cmplt) begin
                        mst_req <= 1'b0;
                        state   <= RELEASE;
                    end else if (tmo_hit) begin
                        mst_req  <= 1'b0;
                        to_pulse <= 1'b1;
                        to_flag  <= 1'b1;
                        state    <= RELEASE;
                    end else if ((state == REQ) && bus.Bus2IP_Mst_CmdAck) begin
                        mst_req <= 1'b0;
                        state   <= WAIT_CMPLT;
                    end
                end
                RELEASE: begin
                    grant_r <= '0;
                    ptr     <= gidx;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_plb_wr_arbiter.sv
// tb/tb_plb_wr_arbiter.sv - randomized self-checking bench for plb_wr_arbiter
module tb_plb_wr_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    plb_wr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

    plb_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int last_g;
    bit flag_m;
    logic [AW-1:0] a_m [N];
    logic [DW-1:0] d_m [N];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++)
            if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic new_payload();
        for (int i = 0; i < N; i++) begin
            a_m[i] = $urandom;
            d_m[i] = $urandom;
            bus_if.req_addr[i*AW +: AW] = a_m[i];
            bus_if.req_data[i*DW +: DW] = d_m[i];
        end
    endtask

    task automatic junk_bus();
        bus_if.Bus2IP_Mst_CmdAck = 1'($urandom);
        bus_if.Bus2IP_Mst_Cmplt  = 1'($urandom);
        bus_if.Bus2IP_Mst_Error  = 1'($urandom);
    endtask

    task automatic run_idle(input int cycles);
        bus_if.req_wr_req = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            junk_bus();
            #1;
            check_val("idle_req",    bus_if.IP2Bus_MstWr_Req, 0);
            check_val("idle_grant",  bus_if.grant, 0);
            check_val("idle_cmplt",  bus_if.req_cmplt, 0);
            check_val("idle_cmdack", bus_if.req_cmdack, 0);
            check_val("idle_flag",   bus_if.timeout_flag, flag_m);
        end
    endtask

    // One granted write; ack_dly / cd are cycles from Req rise to CmdAck and CmdAck to Cmplt.
    task automatic run_txn(input logic [N-1:0] mask, input int ack_dly, input int cd,
                           input bit err, input bit drop);
        int g, cmplt_idx, end_idx;
        bit normal;
        logic [N-1:0] oh, e_ack, e_cmp, e_err, e_gnt;
        bus_if.req_wr_req = mask;
        g = rr_pick(last_g, mask);
        oh = '0;
        oh[g] = 1'b1;
        cmplt_idx = ack_dly + cd;
        normal    = (cmplt_idx <= T - 1);
        end_idx   = normal ? cmplt_idx : T - 1;
        for (int i = 0; i <= end_idx + 2; i++) begin
            @(negedge clk);
            if (i <= end_idx) begin
                bus_if.Bus2IP_Mst_CmdAck = (i == ack_dly);
                bus_if.Bus2IP_Mst_Cmplt  = normal && (i == cmplt_idx);
                bus_if.Bus2IP_Mst_Error  = bus_if.Bus2IP_Mst_Cmplt ? err : 1'($urandom);
            end else begin
                junk_bus();
            end
            #1;
            e_ack = (i == ack_dly && i <= end_idx) ? oh : '0;
            e_cmp = (normal ? (i == cmplt_idx) : (i == T)) ? oh : '0;
            e_err = (normal ? (i == cmplt_idx && err) : (i == T)) ? oh : '0;
            e_gnt = (i <= end_idx + 1) ? oh : '0;
            check_val("req",    bus_if.IP2Bus_MstWr_Req, (i <= ack_dly && i <= end_idx));
            check_val("grant",  bus_if.grant, e_gnt);
            check_val("cmdack", bus_if.req_cmdack, e_ack);
            check_val("cmplt",  bus_if.req_cmplt, e_cmp);
            check_val("error",  bus_if.req_error, e_err);
            check_val("tflag",  bus_if.timeout_flag, flag_m || (!normal && i >= T));
            check_val("data",   bus_if.IP2Bus_MstWr_d, (i <= end_idx + 1) ? d_m[g] : '0);
            if (i <= end_idx + 1)
                check_val("addr", bus_if.IP2Bus_Mst_Addr, a_m[g]);
            if (drop && i == 0)
                bus_if.req_wr_req[g] = 1'b0;
        end
        last_g = g;
        if (!normal) flag_m = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus_if.req_wr_req = '0;
        bus_if.req_addr   = '0;
        bus_if.req_data   = '0;
        bus_if.Bus2IP_Mst_CmdAck = 1'b0;
        bus_if.Bus2IP_Mst_Cmplt  = 1'b0;
        bus_if.Bus2IP_Mst_Error  = 1'b0;
        last_g = N - 1;
        flag_m = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_req",   bus_if.IP2Bus_MstWr_Req, 0);
        check_val("rst_grant", bus_if.grant, 0);
        check_val("rst_addr",  bus_if.IP2Bus_Mst_Addr, 0);
        check_val("rst_flag",  bus_if.timeout_flag, 0);
        check_val("rst_cmplt", bus_if.req_cmplt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        new_payload();
        a_m[0] = 32'h1000_0040;
        d_m[0] = 32'hDEAD_BEEF;
        bus_if.req_addr[0 +: AW] = a_m[0];
        bus_if.req_data[0 +: DW] = d_m[0];
        run_txn(3'b001, 2, 3, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            new_payload();
            run_txn(3'b011, 0, 0, 1'b0, 1'b0);
        end

        new_payload();
        run_txn(3'b010, 1, 2, 1'b1, 1'b0);
        new_payload();
        run_txn(3'b010, 3, 1, 1'b0, 1'b1);
        new_payload();
        run_txn(3'b011, 99, 0, 1'b0, 1'b0);
        new_payload();
        run_txn(3'b011, 1, 1, 1'b0, 1'b0);

        // Reset while req1 sits in WAIT_CMPLT; pointer must restart so req0 wins next.
        new_payload();
        bus_if.req_wr_req = 3'b010;
        @(negedge clk);
        bus_if.Bus2IP_Mst_CmdAck = 1'b1;
        #1;
        check_val("r5_grant", bus_if.grant, 3'b010);
        @(negedge clk);
        bus_if.Bus2IP_Mst_CmdAck = 1'b0;
        #1;
        check_val("r5_req_wait", bus_if.IP2Bus_MstWr_Req, 0);
        @(negedge clk);
        bus_if.Bus2IP_Mst_Cmplt = 1'b1;
        reset_n = 1'b0;
        #1;
        check_val("r5_req",   bus_if.IP2Bus_MstWr_Req, 0);
        check_val("r5_gnt",   bus_if.grant, 0);
        check_val("r5_cmplt", bus_if.req_cmplt, 0);
        check_val("r5_err",   bus_if.req_error, 0);
        check_val("r5_flag",  bus_if.timeout_flag, 0);
        check_val("r5_addr",  bus_if.IP2Bus_Mst_Addr, 0);
        bus_if.Bus2IP_Mst_Cmplt = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        last_g = N - 1;
        flag_m = 1'b0;
        new_payload();
        run_txn(3'b111, 1, 1, 1'b0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            int ack, cd;
            if ($urandom_range(0, 9) == 0) begin
                run_idle($urandom_range(1, 4));
            end else begin
                ack = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
                cd  = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 15) : $urandom_range(0, 3);
                new_payload();
                run_txn(N'($urandom_range(1, (1 << N) - 1)), ack, cd,
                        1'($urandom), ($urandom_range(0, 3) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
